// File: rtl/shift_collector_if.sv
// Serial-bit in / parallel-word out bus for shift_collector.
// Optional word_parity exists only when SHIFT_COLLECTOR_PARITY_EN is defined.
interface shift_collector_if #(
    parameter int unsigned WIDTH = 4
);
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic             select;
    logic             flush;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             busy;
`ifdef SHIFT_COLLECTOR_PARITY_EN
    logic             word_parity;
`endif

    // Producer/consumer side: drives bits and control, receives the word.
    modport master (
        output bit_in,
        output bit_valid,
        input  bit_ready,
        output select,
        output flush,
        input  word_out,
        input  word_valid,
        output word_ready,
`ifdef SHIFT_COLLECTOR_PARITY_EN
        input  word_parity,
`endif
        input  busy
    );

    // Collector side.
    modport slave (
        input  bit_in,
        input  bit_valid,
        output bit_ready,
        input  select,
        input  flush,
        output word_out,
        output word_valid,
        input  word_ready,
`ifdef SHIFT_COLLECTOR_PARITY_EN
        output word_parity,
`endif
        output busy
    );
endinterface

// File: rtl/shift_collector.sv
// Reassembles bits shifted off the ALU shifter boundary into WIDTH-bit words (valid/ready out).
// Define SHIFT_COLLECTOR_PARITY_EN to add a registered even-parity output word_parity.
module shift_collector #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    shift_collector_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q, dir_d;
    logic             accept;
    logic             shift_dir;
    logic [WIDTH-1:0] shift_left, shift_right, shifted;

    // A single-bit word degenerates to a plain load in either direction.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shift_left  = bus.bit_in;
            assign shift_right = bus.bit_in;
        end else begin : g_wn
            assign shift_left  = {shreg_q[WIDTH-2:0], bus.bit_in};
            assign shift_right = {bus.bit_in, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // Direction is latched with the first bit; select is ignored for the rest of the word.
    assign shift_dir = (state_q == StIdle) ? bus.select : dir_q;
    assign shifted   = shift_dir ? shift_right : shift_left;

    assign bus.bit_ready  = (state_q != StHold);
    assign bus.word_valid = (state_q == StHold);
    assign bus.busy       = (state_q == StCollect);
    assign bus.word_out   = shreg_q;
    assign accept         = bus.bit_valid & bus.bit_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shreg_d = shreg_q;
        dir_d   = dir_q;
        if (bus.flush) begin
            // Flush drops any bit offered this cycle; shreg keeps its last contents.
            state_d = StIdle;
            count_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        dir_d   = bus.select;
                        count_d = CNT_ONE;
                        shreg_d = shifted;
                        state_d = (CNT_MAX == CNT_ONE) ? StHold : StCollect;
                    end
                end
                StCollect: begin
                    if (accept) begin
                        count_d = count_q + CNT_ONE;
                        shreg_d = shifted;
                        if (count_q + CNT_ONE == CNT_MAX) begin
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (bus.word_ready) begin
                        state_d = StIdle;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            shreg_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            dir_q   <= dir_d;
        end
    end

`ifdef SHIFT_COLLECTOR_PARITY_EN
    logic parity_q, parity_d;

    // Tracks shreg so parity and word_out change on the same edge.
    always_comb begin
        parity_d = parity_q;
        if (bus.flush) begin
            parity_d = 1'b0;
        end else if (shreg_d != shreg_q || state_d != state_q) begin
            parity_d = ^shreg_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.word_parity = parity_q;
`endif
endmodule
